// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch-address sequencer.
// Optional build feature: PC_ALIGN_CHECK_EN (see pc_target_sel).
package cpu_pkg;

  localparam int unsigned PC_XLEN = 32;
  localparam int unsigned PC_INC  = 4;
  localparam logic [PC_XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {BOOT, RUN, WAIT} pc_state_t;

  // Encoding order doubles as redirect priority (higher value wins).
  typedef enum logic [1:0] {SRC_SEQ, SRC_JMP, SRC_BR, SRC_TRAP} pc_src_t;

  function automatic logic src_wins(input pc_src_t new_src, input pc_src_t old_src);
    return (new_src >= old_src);
  endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Priority select of the redirect target (trap > branch > jump) with alignment handling.
// PC_ALIGN_CHECK_EN: misaligned targets divert to trap_vec_i; otherwise bits [1:0] are cleared.
module pc_target_sel
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = PC_XLEN
) (
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            jmp_i,
  input  logic [XLEN-1:0] jmp_target_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] target_o,
  output pc_src_t         src_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] w_raw;

  always_comb begin
    w_raw      = '0;
    src_o      = SRC_SEQ;
    redirect_o = 1'b0;
    misalign_o = 1'b0;
    target_o   = '0;
    if (trap_i) begin
      w_raw      = trap_vec_i;
      src_o      = SRC_TRAP;
      redirect_o = 1'b1;
    end else if (br_taken_i) begin
      w_raw      = br_target_i;
      src_o      = SRC_BR;
      redirect_o = 1'b1;
    end else if (jmp_i) begin
      w_raw      = jmp_target_i;
      src_o      = SRC_JMP;
      redirect_o = 1'b1;
    end
`ifdef PC_ALIGN_CHECK_EN
    misalign_o = redirect_o && (w_raw[1:0] != 2'b00);
    target_o   = misalign_o ? trap_vec_i : w_raw;
    // A diverted target behaves like a trap for pending-redirect arbitration.
    if (misalign_o) src_o = SRC_TRAP;
`else
    target_o   = w_raw & ~(XLEN'(3));
`endif
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: arbitrates redirects, runs the imem valid/ready handshake, drives flush/squash.
// Optional build feature: PC_ALIGN_CHECK_EN (misaligned redirect -> trap vector, misalign_o pulse).
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN         = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            jmp_i,
  input  logic [XLEN-1:0] jmp_target_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic            fetch_valid_o,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] fetch_addr_o,
  output logic            fetch_squash_o,
  output logic            flush_if_o,
  output logic            flush_id_o,
  output logic            misalign_o
);

  pc_state_t       r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_pend_vld, w_pend_vld_nxt;
  logic [XLEN-1:0] r_pend_addr, w_pend_addr_nxt;
  pc_src_t         r_pend_src, w_pend_src_nxt;

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  pc_src_t         w_src;
  logic            w_misalign;
  logic            w_accept;
  logic            w_stuck;
  logic            w_take_new;

  pc_target_sel #(.XLEN(XLEN)) u_target_sel (
    .trap_i      (trap_i),
    .trap_vec_i  (trap_vec_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .jmp_i       (jmp_i),
    .jmp_target_i(jmp_target_i),
    .redirect_o  (w_redirect),
    .target_o    (w_target),
    .src_o       (w_src),
    .misalign_o  (w_misalign)
  );

  assign flush_if_o   = w_redirect;
  assign flush_id_o   = trap_i | br_taken_i | w_misalign;
  assign misalign_o   = w_misalign;
  assign fetch_addr_o = r_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= BOOT;
      r_pc        <= RESET_VECTOR;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_pend_src  <= SRC_SEQ;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_pend_src  <= w_pend_src_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_addr_nxt = r_pend_addr;
    w_pend_src_nxt  = r_pend_src;
    fetch_valid_o   = 1'b0;
    fetch_squash_o  = 1'b0;

    case (r_state)
      BOOT:    w_state_nxt   = RUN;
      RUN:     fetch_valid_o = !stall_i;
      WAIT:    fetch_valid_o = 1'b1;
      default: w_state_nxt   = BOOT;
    endcase

    w_accept   = fetch_valid_o && fetch_ready_i;
    w_stuck    = fetch_valid_o && !fetch_ready_i;
    w_take_new = w_redirect && (!r_pend_vld || src_wins(w_src, r_pend_src));

    if (w_stuck) begin
      // Request outstanding: hold the address, park any redirect until accept.
      w_state_nxt = WAIT;
      if (w_take_new) begin
        w_pend_vld_nxt  = 1'b1;
        w_pend_addr_nxt = w_target;
        w_pend_src_nxt  = w_src;
      end
    end else begin
      if (r_state == WAIT) w_state_nxt = RUN;
      w_pend_vld_nxt = 1'b0;
      w_pend_src_nxt = SRC_SEQ;
      fetch_squash_o = w_accept && (w_redirect || r_pend_vld);
      if (w_take_new)    w_pc_nxt = w_target;
      else if (r_pend_vld) w_pc_nxt = r_pend_addr;
      else if (w_accept) w_pc_nxt = r_pc + XLEN'(PC_INC);
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-address controller for the RV32I pipeline; owns the architectural fetch PC and replaces the ad-hoc next_pc mux in front of the program counter.
- Arbitrates PC sources: sequential +4, ID jumps, EX branches and traps. Applies hazard stalls.
- Runs a valid/ready handshake to instruction memory and emits pipeline flush/squash controls.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- XLEN, 32, address width (only 32 supported)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- stall_i  in  1  hazard unit request to hold fetch
- jmp_i  in  1  JAL/JALR resolved in ID
- jmp_target_i  in  XLEN  jump target
- br_taken_i  in  1  branch taken, resolved in EX
- br_target_i  in  XLEN  branch target
- trap_i  in  1  exception/trap request
- trap_vec_i  in  XLEN  trap handler address (mtvec)
- fetch_valid_o  out  1  fetch request valid
- fetch_ready_i  in  1  imem accepts request
- fetch_addr_o  out  XLEN  fetch address (current PC)
- fetch_squash_o  out  1  accepted fetch is stale; IF/ID must discard it
- flush_if_o  out  1  kill IF/ID contents
- flush_id_o  out  1  kill ID/EX contents
- misalign_o  out  1  target misaligned pulse (optional feature)

Behaviour:
- Reset (rst=0, async):
  - state=BOOT, fetch_addr_o=RESET_VECTOR.
  - fetch_valid_o=0, fetch_squash_o=0, flush_if_o=0, flush_id_o=0, misalign_o=0.
  - Pending-redirect register cleared.
  - Reset mid-transaction abandons any outstanding request with no handshake completion.
- States:
  - BOOT: 1 cycle after reset release, valid=0, then RUN.
  - RUN: valid = !stall_i. If valid&&!ready, go to WAIT.
  - WAIT: valid=1 and fetch_addr_o held stable until ready. Stall is ignored in WAIT. On accept, go to RUN.
- Redirect priority: trap_i > br_taken_i > jmp_i. Exactly one target is selected per cycle.
- Flush outputs (combinational, same cycle as the redirect):
  - flush_if_o = any redirect.
  - flush_id_o = trap_i | br_taken_i.
- Address update, RUN with no outstanding request (valid=0, or accepted this cycle):
  - redirect: fetch_addr_o <= target next cycle.
  - otherwise, on accept: fetch_addr_o <= fetch_addr_o + 4. Wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
  - stall without redirect: address held.
  - Redirect overrides stall: the address still updates.
- Redirect while valid&&!ready (WAIT, or entering WAIT):
  - Address held stable. Target is latched into the pending register.
  - A later higher-or-equal-priority redirect overwrites the pending target.
  - On accept: fetch_squash_o=1 that cycle and fetch_addr_o <= pending target; pending is cleared.
- Redirect in the same cycle as an accept: fetch_squash_o=1 and fetch_addr_o <= new target.
- Redirect with stall_i in the same cycle: flushes are asserted and the address updates. valid stays 0 until the stall clears.
- Latency: redirect at cycle N gives fetch_valid_o with the target at N+1, if not stalled and nothing is outstanding.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A selected redirect target with [1:0]!=0 is replaced by trap_vec_i.
  - misalign_o pulses for 1 cycle, same cycle as the redirect.
  - flush_id_o is also asserted in that cycle.
- Undefined:
  - Target bits [1:0] are forced to 0.
  - misalign_o is tied to 0.

Decomposition:
- Shared package (cpu_pkg):
  - typedef enum {BOOT, RUN, WAIT} pc_state_t
  - typedef enum {SRC_SEQ, SRC_JMP, SRC_BR, SRC_TRAP} pc_src_t
  - constant PC_INC = 4
  - RESET_VECTOR default value
- Sub-module pc_target_sel: combinational priority select and alignment check. Outputs selected target, redirect flag, src.

Test Plan:
- Reset release, ready=1 -> BOOT one cycle with valid=0; then fetches at 0x0, 0x4, 0x8 on consecutive cycles.
- br_taken_i=1 target 0x100 and jmp_i=1 target 0x200 in the same cycle -> flush_if_o=1, flush_id_o=1; next fetch_addr_o=0x100.
- ready=0 for 3 cycles at addr 0x40; jmp to 0x80 in cycle 1, branch to 0xC0 in cycle 2 -> addr held at 0x40; on accept fetch_squash_o=1; next addr 0xC0.
- stall_i=1 for 2 cycles at 0x20 -> valid=0 and addr 0x20 held; trap_i with vector 0x300 during stall -> addr 0x300 and flush_if_o=flush_id_o=1.
- PC at 0xFFFF_FFFC accepted -> next fetch_addr_o=0x0000_0000.
- Misaligned target (2 checks):
  - With PC_ALIGN_CHECK_EN: jmp target 0x102, trap_vec 0x300 -> misalign_o pulse, next addr 0x300.
  - Without it: next addr 0x100.
